// File: rtl/seq_multiplier.sv
// Radix-2 shift-add sequential multiplier, signed or unsigned, one result every WIDTH+2 cycles.
// Signed operands are reduced to magnitudes up front and the product is negated on the way out.
module seq_multiplier #(
    parameter int WIDTH = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               signed_mode,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    output logic [2*WIDTH-1:0] p,
    output logic               busy,
    output logic               done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t           state;
    state_t           state_next;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [2*WIDTH:0] acc;
    logic [2*WIDTH:0] addend;
    logic [2*WIDTH:0] acc_next;
    logic [CW-1:0]    cnt;
    logic             neg;

    // Unsigned negation also gives 2^(WIDTH-1) for the most negative operand.
    always_comb begin
        mag_a = (signed_mode && a[WIDTH-1]) ? -a : a;
        mag_b = (signed_mode && b[WIDTH-1]) ? -b : b;
    end

    always_comb begin
        addend   = acc[0] ? {1'b0, mcand, {WIDTH{1'b0}}} : '0;
        acc_next = (acc + addend) >> 1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = CALC;
            CALC:    if (cnt == LAST) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        busy = (state != IDLE);
        done = (state == DONE);
    end

    // Low half of acc starts as the multiplier and is consumed one bit per step.
    always_ff @(posedge clk) begin
        if (rst) begin
            mcand <= '0;
            acc   <= '0;
            cnt   <= '0;
            neg   <= 1'b0;
            p     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        mcand <= mag_a;
                        acc   <= {{(WIDTH + 1){1'b0}}, mag_b};
                        cnt   <= '0;
                        neg   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                    end
                end
                CALC: begin
                    acc <= acc_next;
                    cnt <= cnt + CW'(1);
                    if (cnt == LAST) begin
                        p <= neg ? -acc_next[2*WIDTH-1:0] : acc_next[2*WIDTH-1:0];
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_multiplier.sv
// Bench for seq_multiplier: directed timing scenarios on 16- and 8-bit instances
// followed by random operands checked against a plain-arithmetic product model.
module tb_seq_multiplier;

    logic        clk = 1'b0;
    logic        rst;
    logic        start16, sm16;
    logic [15:0] a16, b16;
    logic [31:0] p16;
    logic        busy16, done16;
    logic        start8, sm8;
    logic [7:0]  a8, b8;
    logic [15:0] p8;
    logic        busy8, done8;

    int checks   = 0;
    int failures = 0;
    int ndone;

    always #5 clk = ~clk;

    seq_multiplier #(.WIDTH(16)) u16 (
        .clk(clk), .rst(rst), .start(start16), .signed_mode(sm16),
        .a(a16), .b(b16), .p(p16), .busy(busy16), .done(done16)
    );

    seq_multiplier #(.WIDTH(8)) u8 (
        .clk(clk), .rst(rst), .start(start8), .signed_mode(sm8),
        .a(a8), .b(b8), .p(p8), .busy(busy8), .done(done8)
    );

    task automatic nextCycle();
        @(posedge clk);
        #1;
    endtask

    // Product of the operands as integers, truncated to the 2*w-bit result field.
    function automatic logic [63:0] refProduct(input int w, input logic sm,
                                               input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        logic [63:0] prod;
        logic [63:0] mask;
        sa = longint'({32'b0, a});
        sb = longint'({32'b0, b});
        if (sm && a[w-1]) sa = sa - (longint'(1) << w);
        if (sm && b[w-1]) sb = sb - (longint'(1) << w);
        prod = 64'(sa * sb);
        mask = (64'd1 << (2 * w)) - 64'd1;
        return prod & mask;
    endfunction

    function automatic logic [63:0] getP(input int w);
        return (w == 16) ? {32'b0, p16} : {48'b0, p8};
    endfunction

    function automatic logic getDone(input int w);
        return (w == 16) ? done16 : done8;
    endfunction

    task automatic applyStimulus(input int w, input logic st, input logic sm,
                                 input logic [31:0] a, input logic [31:0] b);
        if (w == 16) begin
            start16 = st; sm16 = sm; a16 = a[15:0]; b16 = b[15:0];
        end else begin
            start8 = st; sm8 = sm; a8 = a[7:0]; b8 = b[7:0];
        end
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Starts one operation, scrambles the inputs afterwards, and waits a bounded time for done.
    task automatic runOp(input int w, input logic sm, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input string tag);
        int lat;
        lat = 0;
        applyStimulus(w, 1'b1, sm, a, b);
        for (int i = 1; i <= w + 4; i++) begin
            nextCycle();
            applyStimulus(w, 1'b0, ~sm, $urandom, $urandom);
            @(negedge clk);
            if (getDone(w)) begin
                lat = i;
                break;
            end
        end
        checkOutput({tag, " latency"}, 64'(lat), 64'(w + 1));
        checkOutput({tag, " p"}, getP(w), exp);
        nextCycle();
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(16, 1'b1, 1'b0, 32'h5, 32'h7);
        applyStimulus(8, 1'b1, 1'b0, 32'h5, 32'h7);
        repeat (3) nextCycle();
        @(negedge clk);
        checkOutput("reset p16", 64'(p16), 64'd0);
        checkOutput("reset busy16", 64'(busy16), 64'd0);
        checkOutput("reset done16", 64'(done16), 64'd0);
        checkOutput("reset p8", 64'(p8), 64'd0);
        checkOutput("reset busy8", 64'(busy8), 64'd0);
        nextCycle();
        rst = 1'b0;
        applyStimulus(16, 1'b0, 1'b0, 32'h0, 32'h0);
        applyStimulus(8, 1'b0, 1'b0, 32'h0, 32'h0);
        nextCycle();

        $display("[TB] unsigned 0xFFFF*0xFFFF cycle timing");
        applyStimulus(16, 1'b1, 1'b0, 32'hFFFF, 32'hFFFF);
        @(negedge clk);
        checkOutput("ffff busy c0", 64'(busy16), 64'd0);
        for (int c = 1; c <= 19; c++) begin
            nextCycle();
            if (c == 1) applyStimulus(16, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("ffff busy c%0d", c), 64'(busy16), 64'(c <= 17));
            checkOutput($sformatf("ffff done c%0d", c), 64'(done16), 64'(c == 17));
            if (c == 17) checkOutput("ffff p", 64'(p16), 64'hFFFE0001);
        end

        $display("[TB] signed corner products");
        runOp(16, 1'b1, 32'hFFFD, 32'h0005, 64'hFFFFFFF1, "s -3*5");
        runOp(16, 1'b1, 32'h8000, 32'h8000, 64'h40000000, "s min*min");
        runOp(16, 1'b1, 32'hFFFF, 32'hFFFF, 64'h00000001, "s -1*-1");
        runOp(16, 1'b1, 32'h0000, 32'h8000, 64'h0, "s zero*min");
        runOp(16, 1'b1, 32'hFFFF, 32'h0000, 64'h0, "s -1*zero");
        runOp(16, 1'b0, 32'h0000, 32'hFFFF, 64'h0, "u zero*ffff");

        $display("[TB] start while busy is ignored");
        ndone = 0;
        applyStimulus(16, 1'b1, 1'b0, 32'd2, 32'd3);
        @(negedge clk);
        for (int c = 1; c <= 40; c++) begin
            nextCycle();
            if (c == 1) applyStimulus(16, 1'b0, 1'b0, 32'd0, 32'd0);
            if (c == 5) applyStimulus(16, 1'b1, 1'b0, 32'd7, 32'd7);
            if (c == 6) applyStimulus(16, 1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            if (done16) ndone++;
            checkOutput($sformatf("repulse done c%0d", c), 64'(done16), 64'(c == 17));
            if (c == 17) checkOutput("repulse p", 64'(p16), 64'd6);
        end
        checkOutput("repulse done count", 64'(ndone), 64'd1);

        $display("[TB] reset aborts a running operation");
        applyStimulus(16, 1'b1, 1'b0, 32'h1234, 32'h0055);
        @(negedge clk);
        for (int c = 1; c <= 30; c++) begin
            nextCycle();
            if (c == 1) applyStimulus(16, 1'b0, 1'b0, 32'd0, 32'd0);
            if (c == 8) rst = 1'b1;
            if (c == 9) rst = 1'b0;
            if (c == 10) applyStimulus(16, 1'b1, 1'b0, 32'd4, 32'd4);
            if (c == 11) applyStimulus(16, 1'b0, 1'b0, 32'd0, 32'd0);
            @(negedge clk);
            checkOutput($sformatf("abort busy c%0d", c), 64'(busy16),
                        64'((c >= 1 && c <= 8) || (c >= 11 && c <= 27)));
            checkOutput($sformatf("abort done c%0d", c), 64'(done16), 64'(c == 27));
            if (c >= 9 && c <= 26) checkOutput($sformatf("abort p c%0d", c), 64'(p16), 64'd0);
            if (c == 27) checkOutput("abort p", 64'(p16), 64'd16);
        end

        $display("[TB] 8-bit single and back-to-back");
        runOp(8, 1'b0, 32'hFF, 32'hFF, 64'hFE01, "u8 ff*ff");
        runOp(8, 1'b1, 32'h80, 32'h80, 64'h4000, "s8 min*min");
        runOp(8, 1'b1, 32'h80, 32'h7F, 64'hC080, "s8 min*max");
        applyStimulus(8, 1'b1, 1'b0, 32'hFF, 32'hFF);
        @(negedge clk);
        for (int c = 1; c <= 30; c++) begin
            nextCycle();
            if (c == 30) applyStimulus(8, 1'b0, 1'b0, 32'h0, 32'h0);
            @(negedge clk);
            checkOutput($sformatf("held done c%0d", c), 64'(done8),
                        64'(c == 9 || c == 19 || c == 29));
            if (c == 9 || c == 19 || c == 29)
                checkOutput($sformatf("held p c%0d", c), 64'(p8), 64'hFE01);
        end
        nextCycle();

        $display("[TB] random operands against the product model");
        for (int wi = 0; wi < 2; wi++) begin
            for (int s = 0; s < 2; s++) begin
                for (int n = 0; n < 1000; n++) begin
                    int w;
                    logic [31:0] ra, rb, mask;
                    w = (wi == 0) ? 16 : 8;
                    mask = (32'd1 << w) - 32'd1;
                    ra = $urandom & mask;
                    rb = $urandom & mask;
                    runOp(w, s[0], ra, rb, refProduct(w, s[0], ra, rb),
                          $sformatf("rand w%0d s%0d a=%0h b=%0h", w, s, ra, rb));
                end
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/seq_multiplier.md
SEQ_MULTIPLIER -- requirements
Module: seq_multiplier

Interface
REQ-001 SHALL have parameter WIDTH, default 16, operand width in bits; legal range 4..32.
REQ-002 SHALL have port clk input 1 — single clock; all state updates on its rising edge.
REQ-003 SHALL have port rst input 1 — reset, synchronous and active-high.
REQ-004 SHALL have port start input 1 — request to begin a multiplication; sampled only in IDLE.
REQ-005 SHALL have port signed_mode input 1 — 1: operands are two's complement; 0: unsigned; sampled with start.
REQ-006 SHALL have port a input WIDTH — multiplicand; sampled with start.
REQ-007 SHALL have port b input WIDTH — multiplier; sampled with start.
REQ-008 SHALL have port p output 2*WIDTH — registered product.
REQ-009 SHALL have port busy output 1 — high while an accepted operation is in progress (CALC or DONE).
REQ-010 SHALL have port done output 1 — single-cycle pulse marking p valid for the new result.

Function
REQ-011 SHALL implement a three-state FSM: IDLE, CALC, DONE.
REQ-012 In IDLE with start=1 at an edge: SHALL capture a, b and signed_mode, clear the accumulator, load the bit counter with 0, and enter CALC.
REQ-013 In signed mode: SHALL capture |a| and |b| as WIDTH-bit unsigned magnitudes and record sign = a[MSB] XOR b[MSB]; the magnitude of -2^(WIDTH-1) is 2^(WIDTH-1), with no overflow.
REQ-014 In unsigned mode: SHALL use a and b unchanged, with sign = 0.
REQ-015 CALC: SHALL perform one radix-2 shift-add step per cycle, adding the multiplicand to the upper half of the accumulator when the current multiplier LSB is 1 and then shifting right by one, with the carry retained in a (2*WIDTH+1)-bit working register.
REQ-016 CALC: SHALL last exactly WIDTH cycles; the counter increments each cycle and the FSM leaves CALC when the counter reaches WIDTH-1.
REQ-017 On leaving CALC: SHALL load p with the accumulator (two's-complement negated when sign=1) and enter DONE.
REQ-018 DONE: SHALL assert done for exactly one cycle, then return to IDLE.
REQ-019 Latency: when start is accepted at edge k, done SHALL be high during the cycle following edge k+WIDTH+1, and p SHALL be valid in that same cycle.
REQ-020 Timing: busy SHALL be high from edge k+1 until edge k+WIDTH+2, and low in IDLE.
REQ-021 p SHALL hold its last result until the next result is loaded; it SHALL NOT change during CALC.
REQ-022 start while busy=1, including the done cycle, SHALL be ignored; the operand and mode inputs SHALL have no effect outside the accepting edge.
REQ-023 Back-to-back operation: start held high continuously SHALL cause acceptance in the first IDLE cycle after done, giving one result every WIDTH+2 cycles.
REQ-024 Zero handling: a zero operand SHALL yield p=0 with the same latency; a negative zero result SHALL NOT occur.
REQ-025 Width: the full 2*WIDTH-bit result SHALL be produced, with no truncation or saturation in either mode.

Reset
REQ-026 rst=1 at any edge SHALL force IDLE, p=0, busy=0, done=0, and clear the counter and accumulator, overriding start.
REQ-027 rst asserted mid-CALC or in DONE SHALL abort the operation; no done pulse SHALL occur for it.
REQ-028 After rst is released, the first edge with start=1 SHALL be accepted normally.

Verification
REQ-029 WIDTH=16, unsigned, a=0xFFFF, b=0xFFFF, start pulsed at edge 0 -> done high only in cycle 17, p=0xFFFE0001, busy high in cycles 1..17.
REQ-030 WIDTH=16, signed: a=0xFFFD (-3), b=0x0005 -> p=0xFFFFFFF1; a=0x8000, b=0x8000 -> p=0x40000000; a=0xFFFF, b=0xFFFF -> p=0x00000001.
REQ-031 WIDTH=16: start at edge 0 with a=2, b=3, and start re-pulsed at edge 5 with a=7, b=7 -> single done at cycle 17 with p=6; no second done.
REQ-032 WIDTH=16: start at edge 0, rst high at edge 8 -> p=0, busy=0, no done through cycle 30; a new start at edge 10 with a=4, b=4 -> done at cycle 27, p=16.
REQ-033 WIDTH=8, unsigned, a=0xFF, b=0xFF -> p=0xFE01 with done in cycle 9; start held high -> done in cycles 9, 19, 29.
REQ-034 Randomized check: 1000 random operand pairs per mode at WIDTH=16 and WIDTH=8 -> p equals the reference product for every done pulse.
